// File: rtl/packet_gen.sv
// BFT leaf traffic generator: LFSR-gated injection, round-robin or LFSR destination,
// retransmission of rejected packets, and done/sent/retry counters for the scoreboard.
module packet_gen #(
    parameter int          num_leaves        = 2,
    parameter int          payload_sz        = 8,
    parameter int          addr              = 0,
    parameter int          num_sent_per_leaf = 10,
    parameter int          inject_thresh     = 13,
    parameter int          dest_mode         = 0,
    parameter logic [15:0] lfsr_seed         = 16'hACE1,
    parameter int          p_sz              = 1 + $clog2(num_leaves) + payload_sz
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     enable,
    input  logic                                     resend,
    output logic [p_sz-1:0]                          bus_o,
    output logic                                     done,
    output logic [$clog2(num_sent_per_leaf+1)-1:0]   sent_cnt,
    output logic [15:0]                              retry_cnt
);

    localparam int              A       = $clog2(num_leaves);
    localparam int              SW      = payload_sz - A;
    localparam int              CW      = $clog2(num_sent_per_leaf + 1);
    localparam logic [A:0]      NL      = (A+1)'(num_leaves);
    localparam logic [A-1:0]    SRC     = A'(addr);
    localparam logic [A-1:0]    RR_INIT = A'((addr + 1) % num_leaves);
    localparam logic [CW-1:0]   N_LAST  = CW'(num_sent_per_leaf);
    localparam logic [8:0]      THRESH  = 9'(inject_thresh);

    typedef enum logic [1:0] {ST_IDLE, ST_GAP, ST_SEND, ST_DONE} state_t;

    state_t          state;
    logic [15:0]     lfsr;
    logic [15:0]     lfsr_next;
    logic [A-1:0]    rr_dest;
    logic [A-1:0]    rr_step;
    logic [A-1:0]    rr_after;
    logic [A-1:0]    lfsr_dest;
    logic [A-1:0]    pick_dest;
    logic            use_rr;
    logic            hit;
    logic [CW-1:0]   cnt_inc;
    logic [CW-1:0]   seq_src;
    logic [p_sz-1:0] next_pkt;

    function automatic logic [A-1:0] wrap_inc(input logic [A-1:0] d);
        return ({1'b0, d} == NL - 1'b1) ? '0 : d + 1'b1;
    endfunction

    always_comb begin
        lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        hit       = enable && ({1'b0, lfsr[7:0]} < THRESH);
        lfsr_dest = lfsr[A+7:8];
        use_rr    = (dest_mode == 0) || ({1'b0, lfsr_dest} >= NL) || (lfsr_dest == SRC);
        pick_dest = use_rr ? rr_dest : lfsr_dest;
        rr_step   = wrap_inc(rr_dest);
        rr_after  = (rr_step == SRC) ? wrap_inc(rr_step) : rr_step;
        cnt_inc   = sent_cnt + 1'b1;
        // a back-to-back load in SEND carries the count that includes the packet accepted on this edge
        seq_src   = (state == ST_SEND) ? cnt_inc : sent_cnt;
        next_pkt  = {1'b1, pick_dest, SRC, SW'(seq_src)};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            lfsr      <= lfsr_seed;
            rr_dest   <= RR_INIT;
            bus_o     <= '0;
            done      <= 1'b0;
            sent_cnt  <= '0;
            retry_cnt <= '0;
        end else begin
            lfsr <= lfsr_next;
            case (state)
                ST_IDLE: begin
                    if (enable) state <= ST_GAP;
                end
                ST_GAP: begin
                    if (hit) begin
                        bus_o <= next_pkt;
                        if (use_rr) rr_dest <= rr_after;
                        state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (resend) begin
                        if (retry_cnt != '1) retry_cnt <= retry_cnt + 1'b1;
                    end else begin
                        sent_cnt <= cnt_inc;
                        if (cnt_inc == N_LAST) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            bus_o <= '0;
                        end else if (hit) begin
                            bus_o <= next_pkt;
                            if (use_rr) rr_dest <= rr_after;
                        end else begin
                            state <= ST_GAP;
                            bus_o <= '0;
                        end
                    end
                end
                ST_DONE: begin
                    bus_o <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_packet_gen.sv
// Self-checking bench for packet_gen: directed vector table, corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_packet_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: nl=4 addr=1 thr=256 rr N=4
    logic        rA = 1'b1, enA = 1'b0, rsA = 1'b0;
    logic [10:0] busA;
    logic        doneA;
    logic [2:0]  sentA;
    logic [15:0] retryA;

    // Instance B: never inject
    logic        rB = 1'b1, enB = 1'b0, rsB = 1'b0;
    logic [10:0] busB;
    logic        doneB;
    logic [2:0]  sentB;
    logic [15:0] retryB;

    // Instance C: LFSR destination, nl=3 addr=0 N=64
    logic        rC = 1'b1, enC = 1'b0, rsC = 1'b0;
    logic [10:0] busC;
    logic        doneC;
    logic [6:0]  sentC;
    logic [15:0] retryC;

    // Instance D: randomized against the reference model
    localparam int D_NL = 3, D_ADDR = 2, D_N = 40, D_THR = 100;
    logic        rD = 1'b1, enD = 1'b0, rsD = 1'b0;
    logic [10:0] busD;
    logic        doneD;
    logic [5:0]  sentD;
    logic [15:0] retryD;

    packet_gen #(.num_leaves(4), .payload_sz(8), .addr(1), .num_sent_per_leaf(4),
                 .inject_thresh(256), .dest_mode(0), .lfsr_seed(16'hACE1)) dut_a (
        .clk(clk), .reset(rA), .enable(enA), .resend(rsA),
        .bus_o(busA), .done(doneA), .sent_cnt(sentA), .retry_cnt(retryA));

    packet_gen #(.num_leaves(4), .payload_sz(8), .addr(1), .num_sent_per_leaf(4),
                 .inject_thresh(0), .dest_mode(0), .lfsr_seed(16'hACE1)) dut_b (
        .clk(clk), .reset(rB), .enable(enB), .resend(rsB),
        .bus_o(busB), .done(doneB), .sent_cnt(sentB), .retry_cnt(retryB));

    packet_gen #(.num_leaves(3), .payload_sz(8), .addr(0), .num_sent_per_leaf(64),
                 .inject_thresh(256), .dest_mode(1), .lfsr_seed(16'hACE1)) dut_c (
        .clk(clk), .reset(rC), .enable(enC), .resend(rsC),
        .bus_o(busC), .done(doneC), .sent_cnt(sentC), .retry_cnt(retryC));

    packet_gen #(.num_leaves(D_NL), .payload_sz(8), .addr(D_ADDR), .num_sent_per_leaf(D_N),
                 .inject_thresh(D_THR), .dest_mode(1), .lfsr_seed(16'h1D2F)) dut_d (
        .clk(clk), .reset(rD), .enable(enD), .resend(rsD),
        .bus_o(busD), .done(doneD), .sent_cnt(sentD), .retry_cnt(retryD));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          rst;
        bit          en;
        bit          rs;
        logic [10:0] bus;
        bit          dn;
        int          sent;
        int          retry;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(bit rst, bit en, bit rs, logic [10:0] bus, bit dn, int sent, int retry);
        vec_t v;
        v.rst = rst; v.en = en; v.rs = rs; v.bus = bus; v.dn = dn; v.sent = sent; v.retry = retry;
        return v;
    endfunction

    // Reference model: one accepted-packet count, a loaded flag and the packet on the wire.
    int          m_lf, m_rr, m_acc, m_retry;
    bit          m_started, m_busy, m_fin;
    logic [10:0] m_bus;

    task automatic model_reset();
        m_lf = 'h1D2F; m_rr = (D_ADDR + 1) % D_NL; m_acc = 0; m_retry = 0;
        m_started = 0; m_busy = 0; m_fin = 0; m_bus = '0;
    endtask

    task automatic model_load(input int seq);
        int cand, dest;
        cand = (m_lf >> 8) % 4;
        if (cand >= D_NL || cand == D_ADDR) begin
            dest = m_rr;
            m_rr = (m_rr + 1) % D_NL;
            if (m_rr == D_ADDR) m_rr = (m_rr + 1) % D_NL;
        end else begin
            dest = cand;
        end
        m_bus  = 11'((1 << 10) + (dest << 8) + (D_ADDR << 6) + (seq % 64));
        m_busy = 1;
    endtask

    task automatic model_step(input bit en, input bit rs);
        bit hit;
        hit = en && ((m_lf % 256) < D_THR);
        if (!m_started) begin
            if (en) m_started = 1;
        end else if (m_fin) begin
        end else if (!m_busy) begin
            if (hit) model_load(m_acc);
        end else if (rs) begin
            if (m_retry < 65535) m_retry++;
        end else begin
            m_acc++;
            if (m_acc == D_N) begin
                m_fin = 1; m_busy = 0; m_bus = '0;
            end else if (hit) begin
                model_load(m_acc);
            end else begin
                m_busy = 0; m_bus = '0;
            end
        end
        m_lf = (m_lf >> 1) ^ ((m_lf % 2 == 1) ? 'hB400 : 0);
    endtask

    logic [10:0] log1[10];
    logic [10:0] log2[10];

    initial begin
        // run 1: always accept; run 2: retry hold; run 3: enable gating and enable dropped during retry
        vecs.push_back(mkv(1,1,0,11'h000,0,0,0));
        vecs.push_back(mkv(0,1,0,11'h640,0,0,0));
        vecs.push_back(mkv(0,1,0,11'h741,0,1,0));
        vecs.push_back(mkv(0,1,0,11'h442,0,2,0));
        vecs.push_back(mkv(0,1,0,11'h643,0,3,0));
        vecs.push_back(mkv(0,1,0,11'h000,1,4,0));
        vecs.push_back(mkv(0,1,1,11'h000,1,4,0));
        vecs.push_back(mkv(1,1,0,11'h000,0,0,0));
        vecs.push_back(mkv(0,1,0,11'h640,0,0,0));
        vecs.push_back(mkv(0,1,0,11'h741,0,1,0));
        vecs.push_back(mkv(0,1,1,11'h741,0,1,1));
        vecs.push_back(mkv(0,1,1,11'h741,0,1,2));
        vecs.push_back(mkv(0,1,1,11'h741,0,1,3));
        vecs.push_back(mkv(0,1,0,11'h442,0,2,3));
        vecs.push_back(mkv(0,1,0,11'h643,0,3,3));
        vecs.push_back(mkv(0,1,0,11'h000,1,4,3));
        vecs.push_back(mkv(1,0,0,11'h000,0,0,0));
        vecs.push_back(mkv(0,0,0,11'h000,0,0,0));
        vecs.push_back(mkv(0,1,0,11'h000,0,0,0));
        vecs.push_back(mkv(0,1,0,11'h640,0,0,0));
        vecs.push_back(mkv(0,0,1,11'h640,0,0,1));
        vecs.push_back(mkv(0,0,0,11'h000,0,1,1));
        vecs.push_back(mkv(0,0,0,11'h000,0,1,1));
        vecs.push_back(mkv(0,0,1,11'h000,0,1,1));
        vecs.push_back(mkv(0,1,0,11'h741,0,1,1));
        vecs.push_back(mkv(0,1,0,11'h442,0,2,1));

        foreach (vecs[i]) begin
            if (vecs[i].rst) begin
                rA = 1'b1; enA = 1'b0; rsA = 1'b0;
                #1;
                chk($sformatf("v%0d_rst_bus", i), busA, 0);
                chk($sformatf("v%0d_rst_done", i), doneA, 0);
                chk($sformatf("v%0d_rst_sent", i), sentA, 0);
                chk($sformatf("v%0d_rst_retry", i), retryA, 0);
                @(negedge clk);
                rA = 1'b0;
            end
            enA = vecs[i].en; rsA = vecs[i].rs;
            @(posedge clk); #1;
            chk($sformatf("v%0d_bus", i), busA, vecs[i].bus);
            chk($sformatf("v%0d_done", i), doneA, vecs[i].dn);
            chk($sformatf("v%0d_sent", i), sentA, vecs[i].sent);
            chk($sformatf("v%0d_retry", i), retryA, vecs[i].retry);
        end

        // reset mid-operation: reference stream, then interrupted run, then replay
        rA = 1'b1; enA = 1'b0; rsA = 1'b0; #1;
        @(negedge clk); rA = 1'b0;
        for (int k = 0; k < 10; k++) begin
            enA = 1'b1; rsA = (k == 3 || k == 4);
            @(posedge clk); #1;
            log1[k] = busA;
        end
        rA = 1'b1; enA = 1'b0; rsA = 1'b0; #1;
        @(negedge clk); rA = 1'b0;
        for (int k = 0; k < 5; k++) begin
            enA = 1'b1; rsA = (k == 3 || k == 4);
            @(posedge clk); #1;
        end
        chk("pre_reset_bus", busA, 11'h741);
        chk("pre_reset_retry", retryA, 2);
        #2; rA = 1'b1; #1;
        chk("async_rst_bus", busA, 0);
        chk("async_rst_sent", sentA, 0);
        chk("async_rst_retry", retryA, 0);
        chk("async_rst_done", doneA, 0);
        enA = 1'b0; rsA = 1'b0;
        @(negedge clk); rA = 1'b0;
        for (int k = 0; k < 10; k++) begin
            enA = 1'b1; rsA = (k == 3 || k == 4);
            @(posedge clk); #1;
            log2[k] = busA;
        end
        for (int k = 0; k < 10; k++) chk($sformatf("replay_%0d", k), log2[k], log1[k]);
        chk("replay_first_pkt", log1[1], 11'h640);

        // never inject
        #1; rB = 1'b1; #1;
        @(negedge clk); rB = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            enB = 1'b1; rsB = 1'b0;
            @(posedge clk); #1;
            chk($sformatf("noinj_bus_%0d", k), busB, 0);
        end
        chk("noinj_done", doneB, 0);
        chk("noinj_sent", sentB, 0);

        // LFSR destination run
        begin
            int npk;
            npk = 0;
            rC = 1'b1; #1;
            @(negedge clk); rC = 1'b0;
            for (int k = 0; k < 300 && !doneC; k++) begin
                enC = 1'b1; rsC = 1'b0;
                @(posedge clk); #1;
                if (busC[10]) begin
                    chk($sformatf("lfsr_dest_%0d", npk), (busC[9:8] == 2'd1 || busC[9:8] == 2'd2), 1);
                    chk($sformatf("lfsr_src_%0d", npk), busC[7:6], 0);
                    chk($sformatf("lfsr_seq_%0d", npk), busC[5:0], npk);
                    npk++;
                end
            end
            chk("lfsr_pkt_count", npk, 64);
            chk("lfsr_done", doneC, 1);
            chk("lfsr_sent", sentC, 64);
        end

        // randomized run against the reference model, with one reset part-way
        for (int c = 0; c < 700; c++) begin
            if (c == 0 || c == 350) begin
                rD = 1'b1; enD = 1'b0; rsD = 1'b0;
                model_reset();
                #1;
                chk($sformatf("rnd_rst_bus_%0d", c), busD, m_bus);
                chk($sformatf("rnd_rst_sent_%0d", c), sentD, m_acc);
                @(negedge clk); rD = 1'b0;
            end
            begin
                bit en, rs;
                en = ($urandom_range(0, 9) < 8);
                rs = ($urandom_range(0, 3) == 0);
                enD = en; rsD = rs;
                model_step(en, rs);
            end
            @(posedge clk); #1;
            chk($sformatf("rnd_bus_%0d", c), busD, m_bus);
            chk($sformatf("rnd_done_%0d", c), doneD, m_fin);
            chk($sformatf("rnd_sent_%0d", c), sentD, m_acc);
            chk($sformatf("rnd_retry_%0d", c), retryD, m_retry);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
